// File: rtl/barrett_pkg.sv
// Shared defaults and elaboration-time helpers for the Barrett reduction blocks.
package barrett_pkg;

    localparam int Q_DEF     = 4057;
    localparam int K_DEF     = 12;
    localparam int DIN_W_DEF = 23;
    localparam int TAG_W_DEF = 4;

    // floor(2**(2k)/q); only ever evaluated on constants at elaboration
    function automatic int mu_calc(input int q, input int k);
        longint num;
        num = longint'(1) << (2 * k);
        return int'(num / longint'(q));
    endfunction

    // Width of the partially reduced remainder, which lies in [0, 4q)
    function automatic int r_width(input int k);
        return k + 2;
    endfunction

endpackage

// File: rtl/barrett_corr.sv
// Final Barrett correction: maps a remainder in [0, 4Q) to [0, Q) using
// parallel compares against 3Q, 2Q and Q.
module barrett_corr
    import barrett_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int K = K_DEF
) (
    input  logic [K+1:0] r,
    output logic [K-1:0] r_mod
);

    localparam int R_W = r_width(K);

    localparam logic [R_W-1:0] Q1_R = R_W'(Q);
    localparam logic [R_W-1:0] Q2_R = R_W'(2 * Q);
    localparam logic [R_W-1:0] Q3_R = R_W'(3 * Q);

    // The corrected result is always below 2**K, so subtracting in K bits is exact
    localparam logic [K-1:0] Q1_K = K'(Q);
    localparam logic [K-1:0] Q2_K = K'(2 * Q);
    localparam logic [K-1:0] Q3_K = K'(3 * Q);

    always_comb begin
        r_mod = r[K-1:0];
        if (r >= Q3_R) begin
            r_mod = r[K-1:0] - Q3_K;
        end else if (r >= Q2_R) begin
            r_mod = r[K-1:0] - Q2_K;
        end else if (r >= Q1_R) begin
            r_mod = r[K-1:0] - Q1_K;
        end
    end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Four-stage pipelined Barrett reducer (dout = din mod Q) with a valid/ready
// stream, backpressure and a tag carried alongside each sample.
module barrett_reduce_pipe
    import barrett_pkg::*;
#(
    parameter int Q     = Q_DEF,
    parameter int K     = K_DEF,
    parameter int DIN_W = DIN_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIN_W-1:0] din,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     dout,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int R_W  = r_width(K);
    localparam int QV_W = DIN_W - K;
    localparam int T_W  = DIN_W - K + 1;
    localparam int P_W  = DIN_W + 1;

    localparam logic [K:0]     MU_V = (K + 1)'(mu_calc(Q, K));
    localparam logic [R_W-1:0] Q_R  = R_W'(Q);
    localparam logic [K-1:0]   Q_K  = K'(Q);

    generate
        if (!((Q > (1 << (K - 1))) && (Q < (1 << K)))) begin : g_bad_q
            $error("barrett_reduce_pipe: Q must satisfy 2**(K-1) < Q < 2**K");
        end
        if (DIN_W > 2 * K) begin : g_bad_din_wide
            $error("barrett_reduce_pipe: DIN_W must not exceed 2*K");
        end
        if (DIN_W < K + 2) begin : g_bad_din_narrow
            $error("barrett_reduce_pipe: DIN_W must be at least K+2");
        end
    endgenerate

    logic             v1, v2, v3, v4;
    logic [R_W-1:0]   a1, a2;
    logic [QV_W-1:0]  qv1;
    logic [T_W-1:0]   t2;
    logic [R_W-1:0]   r3;
    logic [K-1:0]     dout_q;
    logic [TAG_W-1:0] tag1, tag2, tag3, tag4;

    logic             stall;
    logic [T_W-1:0]   t_next;
    logic [R_W-1:0]   r_next;
    logic [K-1:0]     corr_out;

    assign stall     = v4 & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v4;
    assign dout      = dout_q;
    assign out_tag   = tag4;
    assign busy      = v1 | v2 | v3 | v4;

    // Quotient estimate kept at full precision; only the low K+2 bits of a
    // are carried since the true remainder a - t*Q is below 4Q.
    assign t_next = T_W'((P_W'(qv1) * P_W'(MU_V)) >> K);
    assign r_next = a2 - R_W'(R_W'(t2) * Q_R);

    barrett_corr #(
        .Q (Q),
        .K (K)
    ) u_corr (
        .r     (r3),
        .r_mod (corr_out)
    );

    // A stall freezes every stage, data and valid bit alike, so the output
    // register stays stable and no sample is dropped or duplicated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            v4     <= 1'b0;
            a1     <= '0;
            qv1    <= '0;
            tag1   <= '0;
            a2     <= '0;
            t2     <= '0;
            tag2   <= '0;
            r3     <= '0;
            tag3   <= '0;
            dout_q <= '0;
            tag4   <= '0;
        end else if (!stall) begin
            v1     <= in_valid;
            a1     <= din[K+1:0];
            qv1    <= din[DIN_W-1:K];
            tag1   <= in_tag;
            v2     <= v1;
            a2     <= a1;
            t2     <= t_next;
            tag2   <= tag1;
            v3     <= v2;
            r3     <= r_next;
            tag3   <= tag2;
            v4     <= v3;
            dout_q <= corr_out;
            tag4   <= tag3;
        end
    end

    a_dout_lt_q: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (dout < Q_K));

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Directed bench for barrett_reduce_pipe at Q=4057/K=12/DIN_W=23 plus a
// second instance at Q=3329/K=12/DIN_W=24.
module tb_barrett_reduce_pipe;

    localparam int Q      = 4057;
    localparam int K      = 12;
    localparam int DIN_W  = 23;
    localparam int TAG_W  = 4;
    localparam int Q2     = 3329;
    localparam int DIN_W2 = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, out_valid, out_ready, busy;
    logic [DIN_W-1:0] din;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [K-1:0]     dout;

    logic              in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [DIN_W2-1:0] din2;
    logic [TAG_W-1:0]  in_tag2, out_tag2;
    logic [K-1:0]      dout2;

    int   total;
    int   bad;
    logic acc, rel;

    typedef struct packed {
        logic [K-1:0]     val;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    barrett_reduce_pipe #(
        .Q(Q), .K(K), .DIN_W(DIN_W), .TAG_W(TAG_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .din(din), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_tag(out_tag),
        .busy(busy)
    );

    barrett_reduce_pipe #(
        .Q(Q2), .K(K), .DIN_W(DIN_W2), .TAG_W(TAG_W)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .din(din2), .in_tag(in_tag2),
        .out_valid(out_valid2), .out_ready(out_ready2), .dout(dout2), .out_tag(out_tag2),
        .busy(busy2)
    );

    // Inputs change on the falling edge; handshakes are sampled 1ns later,
    // i.e. they describe what the next rising edge will do.
    task automatic drive_cycle(input logic iv, input logic [DIN_W-1:0] d,
                               input logic [TAG_W-1:0] t, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        din       = d;
        in_tag    = t;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        rel = out_valid && out_ready;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (dout !== '0) begin bad++; $display("[TB] FAIL reset_dout: got %0d want 0", dout); end
        total++; if (out_tag !== '0) begin bad++; $display("[TB] FAIL reset_out_tag: got %0d want 0", out_tag); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [DIN_W-1:0] dv [4];
        logic [K-1:0]     ev [4];
        dv[0] = 23'd0;    ev[0] = 12'd0;
        dv[1] = 23'd4056; ev[1] = 12'd4056;
        dv[2] = 23'd4057; ev[2] = 12'd0;
        dv[3] = 23'd8114; ev[3] = 12'd0;
        for (int i = 0; i < 4; i++) begin
            int lat;
            lat = 0;
            drive_cycle(1'b1, dv[i], TAG_W'(i + 5), 1'b1);
            total++; if (acc !== 1'b1) begin bad++; $display("[TB] FAIL basic_accept%0d: got %b want 1", i, acc); end
            for (int n = 1; n <= 10; n++) begin
                drive_cycle(1'b0, '0, '0, 1'b1);
                if (out_valid === 1'b1) begin
                    lat = n;
                    break;
                end
            end
            total++; if (lat != 4) begin bad++; $display("[TB] FAIL basic_latency%0d: got %0d want 4", i, lat); end
            total++; if (dout !== ev[i]) begin bad++; $display("[TB] FAIL basic_dout%0d: got %0d want %0d", i, dout, ev[i]); end
            total++; if (out_tag !== TAG_W'(i + 5)) begin bad++; $display("[TB] FAIL basic_tag%0d: got %0d want %0d", i, out_tag, i + 5); end
        end
    endtask

    task automatic test_range;
        logic [DIN_W-1:0] dv [2];
        logic [K-1:0]     ev [2];
        dv[0] = 23'd8388607; ev[0] = 12'd2788;
        dv[1] = 23'd8385819; ev[1] = 12'd0;
        for (int i = 0; i < 2; i++) begin
            int lat;
            lat = 0;
            drive_cycle(1'b1, dv[i], TAG_W'(i + 12), 1'b1);
            for (int n = 1; n <= 10; n++) begin
                drive_cycle(1'b0, '0, '0, 1'b1);
                if (out_valid === 1'b1) begin
                    lat = n;
                    break;
                end
            end
            total++; if (lat != 4) begin bad++; $display("[TB] FAIL range_latency%0d: got %0d want 4", i, lat); end
            total++; if (dout !== ev[i]) begin bad++; $display("[TB] FAIL range_dout%0d: got %0d want %0d", i, dout, ev[i]); end
            total++; if (out_tag !== TAG_W'(i + 12)) begin bad++; $display("[TB] FAIL range_tag%0d: got %0d want %0d", i, out_tag, i + 12); end
        end
    endtask

    task automatic test_back_to_back;
        int sent, recv, first_c, last_c;
        sent = 0; recv = 0; first_c = -1; last_c = -1;
        exp_q.delete();
        for (int c = 0; c < 1100 && recv < 1000; c++) begin
            logic [DIN_W-1:0] d;
            exp_t e;
            d = DIN_W'($urandom_range(0, (1 << DIN_W) - 1));
            drive_cycle(sent < 1000, d, TAG_W'(sent), 1'b1);
            if (rel) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("[TB] FAIL b2b_extra: got result %0d want none", dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e.val || out_tag !== e.tag) begin
                        bad++; $display("[TB] FAIL b2b_result%0d: got %0d/%0d want %0d/%0d", recv, dout, out_tag, e.val, e.tag);
                    end
                end
                recv++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (acc) begin
                exp_q.push_back('{val: K'(d % Q), tag: TAG_W'(sent)});
                sent++;
            end
        end
        total++; if (recv != 1000) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 1000", recv); end
        total++; if (last_c - first_c != 999) begin bad++; $display("[TB] FAIL b2b_throughput: got span %0d want 999", last_c - first_c); end
    endtask

    task automatic test_stall;
        int sent, recv, held;
        sent = 0; recv = 0; held = 0;
        exp_q.delete();
        for (int c = 0; c < 40 && recv < 8; c++) begin
            logic [DIN_W-1:0] d;
            exp_t e;
            d = DIN_W'(sent * 1234567 + 99);
            drive_cycle(sent < 8, d, TAG_W'(sent + 8), c >= 11);
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                held++;
                total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready: got %b want 0", in_ready); end
                total++;
                if (exp_q.size() == 0 || dout !== exp_q[0].val || out_tag !== exp_q[0].tag) begin
                    bad++; $display("[TB] FAIL stall_hold: got %0d/%0d want head of queue", dout, out_tag);
                end
            end
            if (rel) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("[TB] FAIL stall_extra: got result %0d want none", dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e.val || out_tag !== e.tag) begin
                        bad++; $display("[TB] FAIL stall_result%0d: got %0d/%0d want %0d/%0d", recv, dout, out_tag, e.val, e.tag);
                    end
                end
                recv++;
            end
            if (acc) begin
                exp_q.push_back('{val: K'(d % Q), tag: TAG_W'(sent + 8)});
                sent++;
            end
        end
        total++; if (held != 7) begin bad++; $display("[TB] FAIL stall_cycles: got %0d want 7", held); end
        total++; if (recv != 8) begin bad++; $display("[TB] FAIL stall_count: got %0d want 8", recv); end
        drive_cycle(1'b0, '0, '0, 1'b1);
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_drain: got busy=%b out_valid=%b want 0/0", busy, out_valid); end
    endtask

    task automatic test_reset_mid;
        int lat, stray;
        lat = 0; stray = 0;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, DIN_W'(i * 777 + 1), TAG_W'(i), 1'b1);
        drive_cycle(1'b0, '0, '0, 1'b1);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midrst_inflight: got busy=%b want 1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_out_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            drive_cycle(1'b0, '0, '0, 1'b1);
            if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("[TB] FAIL midrst_stray: got %0d active cycles want 0", stray); end
        drive_cycle(1'b1, 23'd12345, 4'd9, 1'b1);
        for (int n = 1; n <= 10; n++) begin
            drive_cycle(1'b0, '0, '0, 1'b1);
            if (out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        total++; if (lat != 4) begin bad++; $display("[TB] FAIL midrst_latency: got %0d want 4", lat); end
        total++; if (dout !== 12'd174 || out_tag !== 4'd9) begin bad++; $display("[TB] FAIL midrst_result: got %0d/%0d want 174/9", dout, out_tag); end
    endtask

    task automatic test_param2;
        logic [DIN_W2-1:0] dv [6];
        logic [K-1:0]      ev [6];
        int sent, recv;
        logic acc2, rel2;
        dv[0] = 24'd0;        ev[0] = 12'd0;
        dv[1] = 24'd3328;     ev[1] = 12'd3328;
        dv[2] = 24'd3329;     ev[2] = 12'd0;
        dv[3] = 24'd16777215; ev[3] = 12'd2384;
        dv[4] = 24'd6658;     ev[4] = 12'd0;
        dv[5] = 24'd6657;     ev[5] = 12'd3328;
        sent = 0; recv = 0;
        for (int c = 0; c < 30 && recv < 6; c++) begin
            @(negedge clk);
            in_valid2 = (sent < 6);
            din2      = (sent < 6) ? dv[sent] : '0;
            in_tag2   = TAG_W'(sent);
            #1;
            acc2 = in_valid2 && in_ready2;
            rel2 = out_valid2 && out_ready2;
            if (rel2) begin
                total++;
                if (dout2 !== ev[recv] || out_tag2 !== TAG_W'(recv)) begin
                    bad++; $display("[TB] FAIL q3329_result%0d: got %0d/%0d want %0d/%0d", recv, dout2, out_tag2, ev[recv], recv);
                end
                total++;
                if (!(dout2 < 12'd3329)) begin
                    bad++; $display("[TB] FAIL q3329_range%0d: got %0d want below 3329", recv, dout2);
                end
                recv++;
            end
            if (acc2) sent++;
        end
        in_valid2 = 1'b0;
        total++; if (recv != 6) begin bad++; $display("[TB] FAIL q3329_count: got %0d want 6", recv); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        din        = '0;
        in_tag     = '0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        din2       = '0;
        in_tag2    = '0;
        out_ready2 = 1'b1;
        acc        = 1'b0;
        rel        = 1'b0;
        test_reset;
        test_basic;
        test_range;
        test_back_to_back;
        test_stall;
        test_reset_mid;
        test_param2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
